stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control block for the lab stopwatch. It consumes the single-cycle tick pulses produced by the clock divider (1 Hz, 2 Hz, 500 Hz, blink) and sequences the minutes/seconds count. It debounces the pause and clear buttons, runs the RUN/PAUSED/ADJUST mode state machine, and drives BCD digits plus a per-digit blank mask to the seven-segment scan logic.

## Interface
Parameters:
- DEB_SAMPLES, 4, number of consecutive identical 500 Hz samples needed to accept a new button level (range 2–15)

Ports:
- clk_100mhz  in  1  system clock; every tick input is synchronous to it
- rst_n  in  1  reset, asynchronous assert, active-low
- tick_1hz  in  1  one-cycle pulse, 1 Hz
- tick_2hz  in  1  one-cycle pulse, 2 Hz
- tick_500hz  in  1  one-cycle pulse, 500 Hz (debounce sample strobe)
- tick_blink  in  1  one-cycle pulse, 5 Hz
- btn_pause  in  1  raw asynchronous button, active-high
- btn_clear  in  1  raw asynchronous button, active-high
- sw_adj  in  1  raw switch, 1 = adjust mode
- sw_sel  in  1  raw switch, 0 = adjust minutes, 1 = adjust seconds
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits, registered
- digit_blank  out  4  [3]=min_tens … [0]=sec_ones, 1 = blank digit
- mode  out  2  00 PAUSED, 01 RUN, 10 ADJUST

## Operation
- Input conditioning: all four raw inputs pass through a 2-flop synchronizer. btn_pause and btn_clear are then debounced: on each tick_500hz, compare the synced level with the accepted level; if different, increment a per-button counter, else clear it; when the counter reaches DEB_SAMPLES, update the accepted level and clear the counter. A 0→1 change of the accepted level produces a one-cycle press pulse. Switches are synchronized only.
- State machine (mode register):
  - PAUSED: press_pause → RUN. sw_adj=1 → ADJUST.
  - RUN: on tick_1hz, increment the count. press_pause → PAUSED. sw_adj=1 → ADJUST.
  - ADJUST: on tick_2hz, increment the selected field only. sw_adj=0 → PAUSED. press_pause is ignored.
  - sw_adj=1 takes priority over press_pause in the same cycle.
- Count arithmetic (BCD, per-digit rollover):
  - RUN: seconds 00–59. 59→00 carries +1 to minutes. Minutes 00–99. 99:59→00:00 wraps with no flag.
  - ADJUST, seconds field: 59→00, no carry.
  - ADJUST, minutes field: 99→00.
- press_clear: sets all digits to 0 in any state; mode is unchanged. If it coincides with an increment tick, clear wins.
- Blink: blink_phase toggles on tick_blink. It is forced to 1 on entry to ADJUST.
  - In ADJUST with blink_phase=0, the selected field's two digit_blank bits are 1; all other bits are 0.
  - Outside ADJUST, digit_blank = 0000.
- Reset (rst_n low, any time, including mid-debounce or mid-adjust): mode=PAUSED, all digits 0, digit_blank=0000, blink_phase=1, debounce counters 0, accepted levels 0, synchronizers 0. No press pulse is generated on reset release.

## Timing
- Digits, mode and digit_blank are registered. They change on the clock edge that samples the qualifying tick or press pulse, and are visible one cycle after the tick input is high.
- Press latency, button edge to press pulse: 2 synchronizer cycles plus DEB_SAMPLES tick_500hz strobes (8 ms at the default, up to one extra strobe of phase).
- A mode change and a tick in the same cycle: the tick is evaluated against the old mode. Example: press_pause in RUN together with tick_1hz still increments.
- sw_adj and sw_sel take effect 2 cycles after they change.
- Glitches shorter than DEB_SAMPLES strobes never produce a press pulse.

## Test plan
- Reset and run: release rst_n, press pause (held 10 strobes) → mode=01. Apply 61 tick_1hz → digits 0,1,0,1 (01:01). digit_blank stays 0000.
- Wraparound: load 99:58 via ADJUST, exit, press pause. Apply 2 tick_1hz → 99:59, then 00:00, and mode stays 01.
- Bounce rejection: toggle btn_pause every 2 strobes for 20 strobes, then hold low → mode unchanged, no press pulse. Hold high for DEB_SAMPLES strobes → exactly one pulse.
- Adjust: sw_adj=1, sw_sel=1 from 00:58. Apply 3 tick_2hz → 00:01 (no carry to minutes). Apply tick_blink → digit_blank=0011. Next tick_blink → 0000. sw_adj=0 → mode=00.
- Clear priority: in RUN at 00:05, assert press_clear in the same cycle as tick_1hz → 00:00, mode stays 01.
- Async reset mid-adjust: in ADJUST at 42:17, pull rst_n low for 1 ns off-edge → outputs go to 00:00, mode=00, digit_blank=0000 immediately. Release → no spurious press pulse.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Bundle of the stopwatch control signals: divider ticks, raw buttons and
// switches coming in, BCD digits, blank mask and mode going out to the
// seven-segment scan logic.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_500hz;
    logic       tick_blink;
    logic       btn_pause;
    logic       btn_clear;
    logic       sw_adj;
    logic       sw_sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] digit_blank;
    logic [1:0] mode;

    // Side that produces ticks and user inputs and consumes the display.
    modport master (
        output tick_1hz, tick_2hz, tick_500hz, tick_blink,
        output btn_pause, btn_clear, sw_adj, sw_sel,
        input  min_tens, min_ones, sec_tens, sec_ones, digit_blank, mode
    );

    // The stopwatch controller itself.
    modport slave (
        input  tick_1hz, tick_2hz, tick_500hz, tick_blink,
        input  btn_pause, btn_clear, sw_adj, sw_sel,
        output min_tens, min_ones, sec_tens, sec_ones, digit_blank, mode
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: input synchronization, button debounce, RUN/PAUSED/ADJUST
// mode machine, BCD minutes:seconds counter and adjust-mode digit blinking.
module stopwatch_ctrl #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    stopwatch_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        MODE_PAUSED = 2'b00,
        MODE_RUN    = 2'b01,
        MODE_ADJUST = 2'b10
    } mode_t;

    localparam logic [3:0] DEB_LAST = 4'(DEB_SAMPLES - 1);

    // ------------------------------------------------------------------
    // Input synchronization: bit 0 pause, 1 clear, 2 adjust, 3 select.
    // ------------------------------------------------------------------
    logic [3:0] raw_in;
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    assign raw_in = {bus.sw_sel, bus.sw_adj, bus.btn_clear, bus.btn_pause};

    // Two-flop synchronizer for every raw input.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 4'b0000;
            sync2_reg <= 4'b0000;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    logic adj_sync;
    logic sel_sync;
    assign adj_sync = sync2_reg[2];
    assign sel_sync = sync2_reg[3];

    // ------------------------------------------------------------------
    // Debounce for the two buttons; press_vec[0] pause, [1] clear.
    // ------------------------------------------------------------------
    logic [1:0] press_vec;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic [3:0] cnt_reg;
            logic       level_reg;
            logic       press_reg;
            logic       synced;

            assign synced = sync2_reg[gi];

            // Accept a new level after DEB_SAMPLES consecutive differing
            // strobes; a rising accepted level emits a one-cycle press.
            always_ff @(posedge clk_100mhz or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg   <= 4'd0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                end else begin
                    press_reg <= 1'b0;
                    if (bus.tick_500hz) begin
                        if (synced != level_reg) begin
                            if (cnt_reg == DEB_LAST) begin
                                level_reg <= synced;
                                cnt_reg   <= 4'd0;
                                press_reg <= synced;
                            end else begin
                                cnt_reg <= cnt_reg + 4'd1;
                            end
                        end else begin
                            cnt_reg <= 4'd0;
                        end
                    end
                end
            end

            assign press_vec[gi] = press_reg;
        end
    endgenerate

    logic press_pause;
    logic press_clear;
    assign press_pause = press_vec[0];
    assign press_clear = press_vec[1];

    // ------------------------------------------------------------------
    // Mode machine, blink phase and blank mask.
    // ------------------------------------------------------------------
    mode_t      mode_reg;
    mode_t      mode_next;
    logic       blink_reg;
    logic       blink_next;
    logic [3:0] blank_reg;
    logic [3:0] blank_next;

    // Next mode (adjust switch beats pause press), next blink phase and
    // the blank mask that goes with them.
    always_comb begin
        mode_next  = mode_reg;
        blink_next = bus.tick_blink ? ~blink_reg : blink_reg;
        blank_next = 4'b0000;
        case (mode_reg)
            MODE_PAUSED: begin
                if (adj_sync)         mode_next = MODE_ADJUST;
                else if (press_pause) mode_next = MODE_RUN;
            end
            MODE_RUN: begin
                if (adj_sync)         mode_next = MODE_ADJUST;
                else if (press_pause) mode_next = MODE_PAUSED;
            end
            MODE_ADJUST: begin
                if (!adj_sync)        mode_next = MODE_PAUSED;
            end
            default: mode_next = MODE_PAUSED;
        endcase
        if ((mode_next == MODE_ADJUST) && (mode_reg != MODE_ADJUST)) begin
            blink_next = 1'b1;
        end
        if ((mode_next == MODE_ADJUST) && !blink_next) begin
            blank_next = sel_sync ? 4'b0011 : 4'b1100;
        end
    end

    // Mode state register with registered blink phase and blank mask.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg  <= MODE_PAUSED;
            blink_reg <= 1'b1;
            blank_reg <= 4'b0000;
        end else begin
            mode_reg  <= mode_next;
            blink_reg <= blink_next;
            blank_reg <= blank_next;
        end
    end

    // ------------------------------------------------------------------
    // BCD count.
    // ------------------------------------------------------------------
    logic [3:0] min_tens_reg, min_ones_reg, sec_tens_reg, sec_ones_reg;
    logic [3:0] min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;
    logic       sec_wrap;

    // Seconds step 00..59 with per-digit rollover.
    function automatic logic [7:0] inc_sec(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            inc_sec = (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
        end else begin
            inc_sec = {tens, ones + 4'd1};
        end
    endfunction

    // Minutes step 00..99 with per-digit rollover.
    function automatic logic [7:0] inc_min(input logic [3:0] tens, input logic [3:0] ones);
        if (ones == 4'd9) begin
            inc_min = (tens == 4'd9) ? 8'h00 : {tens + 4'd1, 4'd0};
        end else begin
            inc_min = {tens, ones + 4'd1};
        end
    endfunction

    assign sec_inc  = inc_sec(sec_tens_reg, sec_ones_reg);
    assign min_inc  = inc_min(min_tens_reg, min_ones_reg);
    assign sec_wrap = (sec_tens_reg == 4'd5) && (sec_ones_reg == 4'd9);

    // Next count: clear wins over any tick; ticks are judged by the
    // current mode, so a mode change on the same edge does not lose them.
    always_comb begin
        min_tens_next = min_tens_reg;
        min_ones_next = min_ones_reg;
        sec_tens_next = sec_tens_reg;
        sec_ones_next = sec_ones_reg;
        if (press_clear) begin
            min_tens_next = 4'd0;
            min_ones_next = 4'd0;
            sec_tens_next = 4'd0;
            sec_ones_next = 4'd0;
        end else if ((mode_reg == MODE_RUN) && bus.tick_1hz) begin
            {sec_tens_next, sec_ones_next} = sec_inc;
            if (sec_wrap) begin
                {min_tens_next, min_ones_next} = min_inc;
            end
        end else if ((mode_reg == MODE_ADJUST) && bus.tick_2hz) begin
            if (sel_sync) begin
                {sec_tens_next, sec_ones_next} = sec_inc;
            end else begin
                {min_tens_next, min_ones_next} = min_inc;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            min_tens_reg <= 4'd0;
            min_ones_reg <= 4'd0;
            sec_tens_reg <= 4'd0;
            sec_ones_reg <= 4'd0;
        end else begin
            min_tens_reg <= min_tens_next;
            min_ones_reg <= min_ones_next;
            sec_tens_reg <= sec_tens_next;
            sec_ones_reg <= sec_ones_next;
        end
    end

    assign bus.min_tens    = min_tens_reg;
    assign bus.min_ones    = min_ones_reg;
    assign bus.sec_tens    = sec_tens_reg;
    assign bus.sec_ones    = sec_ones_reg;
    assign bus.digit_blank = blank_reg;
    assign bus.mode        = mode_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: run, clear priority, bounce rejection,
// adjust with blink, wraparound and asynchronous reset mid-adjust.
`timescale 1ns/100ps
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    stopwatch_ctrl_if sw_bus ();

    stopwatch_ctrl #(.DEB_SAMPLES(4)) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .bus        (sw_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {sw_bus.min_tens, sw_bus.min_ones, sw_bus.sec_tens, sw_bus.sec_ones};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick1(input int n);
        repeat (n) begin
            @(negedge clk) sw_bus.tick_1hz = 1'b1;
            @(negedge clk) sw_bus.tick_1hz = 1'b0;
        end
    endtask

    task automatic tick2(input int n);
        repeat (n) begin
            @(negedge clk) sw_bus.tick_2hz = 1'b1;
            @(negedge clk) sw_bus.tick_2hz = 1'b0;
        end
    endtask

    task automatic blink();
        @(negedge clk) sw_bus.tick_blink = 1'b1;
        @(negedge clk) sw_bus.tick_blink = 1'b0;
        cyc(1);
    endtask

    task automatic strobes(input int n);
        repeat (n) begin
            @(negedge clk) sw_bus.tick_500hz = 1'b1;
            @(negedge clk) sw_bus.tick_500hz = 1'b0;
            @(negedge clk);
        end
    endtask

    // Full press and release of one button: 0 = pause, 1 = clear.
    task automatic press(input int which);
        if (which == 0) sw_bus.btn_pause = 1'b1; else sw_bus.btn_clear = 1'b1;
        cyc(3);
        strobes(10);
        if (which == 0) sw_bus.btn_pause = 1'b0; else sw_bus.btn_clear = 1'b0;
        cyc(3);
        strobes(6);
    endtask

    initial begin
        rst_n = 1'b0;
        sw_bus.tick_1hz = 1'b0;   sw_bus.tick_2hz = 1'b0;
        sw_bus.tick_500hz = 1'b0; sw_bus.tick_blink = 1'b0;
        sw_bus.btn_pause = 1'b0;  sw_bus.btn_clear = 1'b0;
        sw_bus.sw_adj = 1'b0;     sw_bus.sw_sel = 1'b0;
        cyc(3);
        check("reset_digits", digits(), 16'h0000);
        check("reset_mode", {14'd0, sw_bus.mode}, 16'h0000);
        check("reset_blank", {12'd0, sw_bus.digit_blank}, 16'h0000);
        rst_n = 1'b1;
        cyc(3);
        check("release_mode", {14'd0, sw_bus.mode}, 16'h0000);

        // Reset and run.
        press(0);
        check("run_mode", {14'd0, sw_bus.mode}, 16'h0001);
        tick1(61);
        cyc(1);
        check("run_61s", digits(), 16'h0101);
        check("run_blank", {12'd0, sw_bus.digit_blank}, 16'h0000);

        // Plain clear keeps RUN.
        press(1);
        check("clear_digits", digits(), 16'h0000);
        check("clear_mode", {14'd0, sw_bus.mode}, 16'h0001);
        tick1(5);
        cyc(1);
        check("run_5s", digits(), 16'h0005);

        // Clear pulse coincident with tick_1hz: clear wins.
        sw_bus.btn_clear = 1'b1;
        cyc(3);
        strobes(3);
        @(negedge clk) sw_bus.tick_500hz = 1'b1;
        @(negedge clk) begin
            sw_bus.tick_500hz = 1'b0;
            sw_bus.tick_1hz = 1'b1;
        end
        @(negedge clk) sw_bus.tick_1hz = 1'b0;
        check("clear_prio_digits", digits(), 16'h0000);
        check("clear_prio_mode", {14'd0, sw_bus.mode}, 16'h0001);
        sw_bus.btn_clear = 1'b0;
        cyc(3);
        strobes(6);

        // Bounce rejection: toggle every 2 strobes for 20 strobes.
        for (int i = 0; i < 10; i++) begin
            sw_bus.btn_pause = (i % 2 == 0);
            cyc(3);
            strobes(2);
        end
        sw_bus.btn_pause = 1'b0;
        cyc(3);
        strobes(6);
        check("bounce_mode", {14'd0, sw_bus.mode}, 16'h0001);
        sw_bus.btn_pause = 1'b1;
        cyc(3);
        strobes(4);
        check("deb_exact_mode", {14'd0, sw_bus.mode}, 16'h0000);
        strobes(4);
        sw_bus.btn_pause = 1'b0;
        cyc(3);
        strobes(6);
        check("deb_one_pulse", {14'd0, sw_bus.mode}, 16'h0000);

        // Adjust seconds with blink.
        sw_bus.sw_sel = 1'b1;
        sw_bus.sw_adj = 1'b1;
        cyc(3);
        check("adj_mode", {14'd0, sw_bus.mode}, 16'h0002);
        check("adj_blank_entry", {12'd0, sw_bus.digit_blank}, 16'h0000);
        tick2(58);
        cyc(1);
        check("adj_58", digits(), 16'h0058);
        tick2(3);
        cyc(1);
        check("adj_sec_nocarry", digits(), 16'h0001);
        blink();
        check("blink_on_sec", {12'd0, sw_bus.digit_blank}, 16'h0003);
        blink();
        check("blink_off", {12'd0, sw_bus.digit_blank}, 16'h0000);
        sw_bus.sw_adj = 1'b0;
        cyc(3);
        check("adj_exit_mode", {14'd0, sw_bus.mode}, 16'h0000);
        check("adj_exit_digits", digits(), 16'h0001);

        // Wraparound: load 99:58, run two seconds.
        sw_bus.sw_sel = 1'b0;
        sw_bus.sw_adj = 1'b1;
        cyc(3);
        tick2(99);
        cyc(1);
        check("adj_min_99", digits(), 16'h9901);
        sw_bus.sw_sel = 1'b1;
        cyc(3);
        tick2(57);
        cyc(1);
        check("adj_9958", digits(), 16'h9958);
        sw_bus.sw_adj = 1'b0;
        cyc(3);
        press(0);
        check("wrap_run_mode", {14'd0, sw_bus.mode}, 16'h0001);
        tick1(1);
        cyc(1);
        check("wrap_9959", digits(), 16'h9959);
        tick1(1);
        cyc(1);
        check("wrap_0000", digits(), 16'h0000);
        check("wrap_mode", {14'd0, sw_bus.mode}, 16'h0001);

        // Load 42:17 in ADJUST, blank the seconds, then reset off-edge.
        sw_bus.sw_sel = 1'b0;
        sw_bus.sw_adj = 1'b1;
        cyc(3);
        check("adj2_mode", {14'd0, sw_bus.mode}, 16'h0002);
        tick2(42);
        sw_bus.sw_sel = 1'b1;
        cyc(3);
        tick2(17);
        cyc(1);
        check("adj_4217", digits(), 16'h4217);
        blink();
        check("adj2_blank", {12'd0, sw_bus.digit_blank}, 16'h0003);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sw_bus.sw_adj = 1'b0;
        #0.5;
        check("areset_digits", digits(), 16'h0000);
        check("areset_mode", {14'd0, sw_bus.mode}, 16'h0000);
        check("areset_blank", {12'd0, sw_bus.digit_blank}, 16'h0000);
        #0.5;
        rst_n = 1'b1;
        cyc(3);
        strobes(6);
        check("post_reset_mode", {14'd0, sw_bus.mode}, 16'h0000);
        check("post_reset_digits", digits(), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
